// File: rtl/word_assembler_if.sv
// Handshake bundle for word_assembler: narrow beat input side and wide word output side.
// slave is the assembler's view; master is the view of whatever drives beats and consumes words.
interface word_assembler_if #(
  parameter int IN_W  = 8,
  parameter int BEATS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  msb_first;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*BEATS-1:0] out_data;
  logic                  out_partial;

  modport slave (
    input  in_valid, in_data, msb_first, flush, out_ready,
    output in_ready, out_valid, out_data, out_partial
  );

  modport master (
    output in_valid, in_data, msb_first, flush, out_ready,
    input  in_ready, out_valid, out_data, out_partial
  );
endinterface

// File: rtl/word_assembler.sv
// Collects BEATS narrow beats into one wide word, with per-word lane order and one beat/cycle throughput.
// WORD_ASSEMBLER_PARTIAL_FLUSH_EN: flush emits a zero-padded partial word instead of discarding it.
module word_assembler #(
  parameter int IN_W  = 8,
  parameter int BEATS = 2,
  parameter int CNT_W = $clog2(BEATS)
) (
  input logic              clk,
  input logic              rst_n,
  word_assembler_if.slave  bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [CNT_W-1:0]      lane;
  logic [IN_W*BEATS-1:0] word, word_nx;
  logic                  msb_lat, msb_nx;
  logic                  order;
  logic                  beat_acc, word_acc, last;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
  logic                  partial, partial_nx;
`endif

  // In HOLD a beat can only enter when the held word leaves in the same cycle
  assign bus.in_ready  = rst_n && ((state == FILL) || bus.out_ready);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = word;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
  assign bus.out_partial = partial;
`else
  assign bus.out_partial = 1'b0;
`endif

  assign beat_acc = bus.in_valid && bus.in_ready;
  assign word_acc = bus.out_valid && bus.out_ready;
  assign last     = (cnt == CNT_W'(BEATS - 1));
  // The first beat uses the live msb_first; later beats follow the latched order
  assign order    = (cnt == '0) ? bus.msb_first : msb_lat;
  assign lane     = order ? (CNT_W'(BEATS - 1) - cnt) : cnt;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    word_nx  = word;
    msb_nx   = msb_lat;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
    partial_nx = partial;
`endif

    if (beat_acc) begin
      if (cnt == '0) begin
        word_nx = '0;
        msb_nx  = bus.msb_first;
      end
      for (int j = 0; j < BEATS; j++) begin
        if (lane == CNT_W'(j)) word_nx[j*IN_W +: IN_W] = bus.in_data;
      end
    end

    if (state == HOLD) begin
      if (word_acc) begin
        state_nx = FILL;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
        partial_nx = 1'b0;
`endif
      end
      if (beat_acc) cnt_nx = CNT_W'(1);
    end else begin
      if (beat_acc) begin
        if (last) begin
          cnt_nx   = '0;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      // Flush acts on the counter as updated by any beat taken this cycle
      if (bus.flush && !(beat_acc && last) && (beat_acc || (cnt != '0))) begin
        cnt_nx = '0;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
        state_nx   = HOLD;
        partial_nx = 1'b1;
`else
        word_nx = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= '0;
      word    <= '0;
      msb_lat <= 1'b0;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
      partial <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      word    <= word_nx;
      msb_lat <= msb_nx;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
      partial <= partial_nx;
`endif
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: a BEATS=2 instance for the main paths and a BEATS=4 instance for flush.
module tb_word_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  word_assembler_if #(.IN_W(8), .BEATS(2)) a ();
  word_assembler_if #(.IN_W(8), .BEATS(4)) b ();

  word_assembler #(.IN_W(8), .BEATS(2)) ua (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  word_assembler #(.IN_W(8), .BEATS(4)) ub (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  task automatic set_a(input logic v, input logic [7:0] d, input logic m, input logic f, input logic r);
    a.in_valid = v; a.in_data = d; a.msb_first = m; a.flush = f; a.out_ready = r;
  endtask

  task automatic set_b(input logic v, input logic [7:0] d, input logic m, input logic f, input logic r);
    b.in_valid = v; b.in_data = d; b.msb_first = m; b.flush = f; b.out_ready = r;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_a got=%b exp=0", a.in_ready); end
    checks++; if (b.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_b got=%b exp=0", b.in_ready); end
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", a.out_valid); end
    checks++; if (a.out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", a.out_data); end
    checks++; if (b.out_partial !== 1'b0) begin failures++; $display("FAIL rst_out_partial got=%b exp=0", b.out_partial); end
    rst_n = 1'b1; #1;
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", a.in_ready); end
  endtask

  task automatic test_basic;
    @(negedge clk); set_a(1, 8'h34, 0, 0, 1);
    @(negedge clk); set_a(1, 8'h12, 0, 0, 1);
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a.out_valid); end
    checks++; if (a.out_data !== 16'h1234) begin failures++; $display("FAIL basic_data got=%h exp=1234", a.out_data); end
    checks++; if (a.out_partial !== 1'b0) begin failures++; $display("FAIL basic_partial got=%b exp=0", a.out_partial); end
    @(negedge clk); #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b exp=0", a.out_valid); end
  endtask

  task automatic test_msb_first;
    @(negedge clk); set_a(1, 8'h34, 1, 0, 1);
    @(negedge clk); set_a(1, 8'h12, 0, 0, 1);
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", a.out_valid); end
    checks++; if (a.out_data !== 16'h3412) begin failures++; $display("FAIL msb_data got=%h exp=3412", a.out_data); end
    @(negedge clk);
  endtask

  task automatic test_stream;
    logic [15:0] exp_words [4];
    exp_words = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) set_a(1, 8'(k + 1), 0, 0, 1);
      else       set_a(0, 8'h00, 0, 0, 1);
      #1;
      if (k < 8) begin
        checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, a.in_ready); end
      end
      if (k >= 1) begin
        checks++; if (a.out_valid !== ((k % 2) == 0)) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, a.out_valid, ((k % 2) == 0)); end
      end
      if (k >= 2 && (k % 2) == 0) begin
        checks++; if (a.out_data !== exp_words[k/2-1]) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, a.out_data, exp_words[k/2-1]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); set_a(1, 8'h34, 0, 0, 0);
    @(negedge clk); set_a(1, 8'h12, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_a(1, 8'hAA, 0, 0, 0); #1;
      checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, a.out_valid); end
      checks++; if (a.out_data !== 16'h1234) begin failures++; $display("FAIL bp_data i=%0d got=%h exp=1234", i, a.out_data); end
      checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready i=%0d got=%b exp=0", i, a.in_ready); end
    end
    @(negedge clk); set_a(1, 8'hAA, 0, 0, 1); #1;
    checks++; if (a.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", a.in_ready); end
    @(negedge clk); set_a(1, 8'hBB, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_accept got=%b exp=0", a.out_valid); end
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); #1;
    checks++; if (a.out_data !== 16'hBBAA) begin failures++; $display("FAIL bp_next_word got=%h exp=bbaa", a.out_data); end
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b exp=1", a.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush_idle_and_complete;
    @(negedge clk); set_a(0, 8'h00, 0, 1, 1);
    @(negedge clk); set_a(1, 8'h01, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_valid got=%b exp=0", a.out_valid); end
    @(negedge clk); set_a(1, 8'h02, 0, 1, 1);
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL flush_full_valid got=%b exp=1", a.out_valid); end
    checks++; if (a.out_data !== 16'h0201) begin failures++; $display("FAIL flush_full_data got=%h exp=0201", a.out_data); end
    checks++; if (a.out_partial !== 1'b0) begin failures++; $display("FAIL flush_full_partial got=%b exp=0", a.out_partial); end
    @(negedge clk);
  endtask

  task automatic test_flush_partial;
    @(negedge clk); set_b(1, 8'h11, 0, 0, 0);
    @(negedge clk); set_b(1, 8'h22, 0, 0, 0);
    @(negedge clk); set_b(0, 8'h00, 0, 1, 0);
    @(negedge clk); set_b(0, 8'h00, 0, 0, 0); #1;
`ifdef WORD_ASSEMBLER_PARTIAL_FLUSH_EN
    checks++; if (b.out_valid !== 1'b1) begin failures++; $display("FAIL part_valid got=%b exp=1", b.out_valid); end
    checks++; if (b.out_data !== 32'h00002211) begin failures++; $display("FAIL part_data got=%h exp=00002211", b.out_data); end
    checks++; if (b.out_partial !== 1'b1) begin failures++; $display("FAIL part_flag got=%b exp=1", b.out_partial); end
    @(negedge clk); set_b(0, 8'h00, 0, 0, 1); #1;
    checks++; if (b.out_partial !== 1'b1) begin failures++; $display("FAIL part_flag_hold got=%b exp=1", b.out_partial); end
    @(negedge clk); #1;
    checks++; if (b.out_valid !== 1'b0) begin failures++; $display("FAIL part_accept got=%b exp=0", b.out_valid); end
    checks++; if (b.out_partial !== 1'b0) begin failures++; $display("FAIL part_flag_clear got=%b exp=0", b.out_partial); end
`else
    checks++; if (b.out_valid !== 1'b0) begin failures++; $display("FAIL discard_valid got=%b exp=0", b.out_valid); end
`endif
    @(negedge clk); set_b(1, 8'h33, 0, 0, 1);
    @(negedge clk); set_b(1, 8'h44, 0, 0, 1);
    @(negedge clk); set_b(1, 8'h55, 0, 0, 1);
    @(negedge clk); set_b(1, 8'h66, 0, 0, 1); #1;
    checks++; if (b.out_valid !== 1'b0) begin failures++; $display("FAIL b4_early_valid got=%b exp=0", b.out_valid); end
    @(negedge clk); set_b(0, 8'h00, 0, 0, 1); #1;
    checks++; if (b.out_valid !== 1'b1) begin failures++; $display("FAIL b4_valid got=%b exp=1", b.out_valid); end
    checks++; if (b.out_data !== 32'h66554433) begin failures++; $display("FAIL b4_data got=%h exp=66554433", b.out_data); end
    checks++; if (b.out_partial !== 1'b0) begin failures++; $display("FAIL b4_partial got=%b exp=0", b.out_partial); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word;
    @(negedge clk); set_a(1, 8'h55, 0, 0, 1);
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); rst_n = 1'b0; #1;
    checks++; if (a.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", a.in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (a.out_data !== 16'h0000) begin failures++; $display("FAIL midrst_data got=%h exp=0000", a.out_data); end
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", a.out_valid); end
    checks++; if (a.out_partial !== 1'b0) begin failures++; $display("FAIL midrst_partial got=%b exp=0", a.out_partial); end
    set_a(1, 8'h77, 0, 0, 1);
    @(negedge clk); set_a(1, 8'h88, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_early got=%b exp=0", a.out_valid); end
    @(negedge clk); set_a(0, 8'h00, 0, 0, 1); #1;
    checks++; if (a.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_word_valid got=%b exp=1", a.out_valid); end
    checks++; if (a.out_data !== 16'h8877) begin failures++; $display("FAIL midrst_word got=%h exp=8877", a.out_data); end
    @(negedge clk);
  endtask

  initial begin
    set_a(0, 8'h00, 0, 0, 0);
    set_b(0, 8'h00, 0, 0, 0);
    test_reset;
    test_basic;
    test_msb_first;
    test_stream;
    test_back_to_back;
    test_flush_idle_and_complete;
    test_flush_partial;
    test_reset_mid_word;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
